mvm_result_drain: RTL and testbench

- Consumer end of the MVM result interface.
- Captures each parallel result group (one OWIDTH word per output lane, qualified by the MVM valid pulse) into a group FIFO.
- Serializes groups lane-by-lane onto a valid/ready stream, since the MVM has no backpressure.
- Snoops the MVM start command to know how many groups to expect, and pulses done when the last word leaves.

---
 rtl/mvm_pkg.sv | 17 +
 rtl/mvm_result_drain_group_fifo.sv | 55 +++++
 rtl/mvm_result_drain.sv | 170 +++++++++++++++++
 tb/tb_mvm_result_drain.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared defaults and types for the MVM result drain.
package mvm_pkg;

    localparam int OWIDTH_DEF     = 32;
    localparam int NUM_OLANES_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 16;
    localparam int MAT_ADDRW_DEF  = 9;

    // One parallel result group: lane 0 first.
    typedef logic [0:NUM_OLANES_DEF-1][OWIDTH_DEF-1:0] result_group_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } drain_state_e;

endpackage

// File: rtl/mvm_result_drain_group_fifo.sv
// Synchronous FIFO of whole result groups; pushes while full are refused
// unless a pop happens in the same cycle.
module group_fifo #(
    parameter  int WIDTH = 256,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wptr_d = do_push ? (wptr_q + PTR_ONE) : wptr_q;
    assign rptr_d = do_pop  ? (rptr_q + PTR_ONE) : rptr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/mvm_result_drain.sv
// Buffers MVM result groups and serializes them lane-by-lane onto a
// valid/ready stream, tracking job completion from the snooped start command.
module mvm_result_drain
    import mvm_pkg::*;
#(
    parameter  int OWIDTH     = OWIDTH_DEF,
    parameter  int NUM_OLANES = NUM_OLANES_DEF,
    parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter  int MAT_ADDRW  = MAT_ADDRW_DEF,
    localparam int LANEW      = $clog2(NUM_OLANES)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_start,
    input  logic [MAT_ADDRW:0]                   i_num_rows_per_olane,
    input  logic [0:NUM_OLANES-1][OWIDTH-1:0]    i_result,
    input  logic                                 i_valid,
    output logic [OWIDTH-1:0]                    o_data,
    output logic [LANEW-1:0]                     o_lane,
    output logic                                 o_last,
    output logic                                 o_valid,
    input  logic                                 i_ready,
    output logic                                 o_overflow,
    input  logic                                 i_clr_overflow,
    output logic                                 o_done,
    output logic                                 o_busy
);

    localparam int GW  = OWIDTH * NUM_OLANES;
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam logic [LANEW-1:0]   LAST_LANE = LANEW'(NUM_OLANES - 1);
    localparam logic [LANEW-1:0]   LANE_ONE  = LANEW'(1);
    localparam logic [MAT_ADDRW:0] CNT_ONE   = (MAT_ADDRW+1)'(1);

    drain_state_e                      state_q, state_d;
    logic [LANEW-1:0]                  lane_q, lane_d;
    logic [0:NUM_OLANES-1][OWIDTH-1:0] group_q, group_d;
    logic [MAT_ADDRW:0]                expected_q, expected_d;
    logic [MAT_ADDRW:0]                emitted_q, emitted_d;
    logic [MAT_ADDRW:0]                emitted_inc;
    logic                              busy_q, busy_d;
    logic                              zero_done_q, zero_done_d;
    logic                              ovf_q, ovf_d;

    logic [GW-1:0] fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FAW:0]  fifo_count;
    logic          fifo_pop;
    logic          xfer;
    logic          at_last;
    logic          final_xfer;
    logic          drop;

    group_fifo #(
        .WIDTH (GW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (i_valid),
        .wdata_i (i_result),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Stream handshake: a word moves when o_valid && i_ready; once o_valid is
    // raised, data/lane/last stay frozen until that transfer happens.
    assign o_valid = (state_q == ST_STREAM);
    assign at_last = (lane_q == LAST_LANE);
    assign xfer    = o_valid && i_ready;
    assign o_data  = o_valid ? group_q[lane_q] : '0;
    assign o_lane  = o_valid ? lane_q : '0;
    assign o_last  = o_valid && at_last;

    assign emitted_inc = emitted_q + CNT_ONE;
    assign final_xfer  = xfer && at_last && busy_q && !i_start && (emitted_inc == expected_q);
    assign o_done      = final_xfer || zero_done_q;
    assign o_busy      = busy_q;
    assign o_overflow  = ovf_q;

    // A full FIFO still takes the push when the serializer pops in the same cycle.
    assign drop = i_valid && fifo_full && !fifo_pop;

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        group_d  = group_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    fifo_pop = 1'b1;
                    group_d  = fifo_rdata;
                    lane_d   = '0;
                    state_d  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xfer) begin
                    if (!at_last) begin
                        lane_d = lane_q + LANE_ONE;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        group_d  = fifo_rdata;
                        lane_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        expected_d  = expected_q;
        emitted_d   = emitted_q;
        busy_d      = busy_q;
        zero_done_d = 1'b0;
        ovf_d       = ovf_q;
        if (i_start) begin
            expected_d  = i_num_rows_per_olane;
            emitted_d   = '0;
            busy_d      = 1'b1;
            zero_done_d = (i_num_rows_per_olane == '0);
        end else begin
            if (zero_done_q) begin
                busy_d = 1'b0;
            end
            if (xfer && at_last && busy_q) begin
                emitted_d = emitted_inc;
                if (emitted_inc == expected_q) begin
                    busy_d = 1'b0;
                end
            end
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            lane_q      <= '0;
            group_q     <= '0;
            expected_q  <= '0;
            emitted_q   <= '0;
            busy_q      <= 1'b0;
            zero_done_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            group_q     <= group_d;
            expected_q  <= expected_d;
            emitted_q   <= emitted_d;
            busy_q      <= busy_d;
            zero_done_q <= zero_done_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mvm_result_drain.sv
// Self-checking bench for mvm_result_drain: job table plus directed corner sequences.
module tb_mvm_result_drain;
    import mvm_pkg::*;

    localparam int OW = 32;
    localparam int NL = 8;
    localparam int EW = OW + 4;

    typedef struct {
        int       rows;
        int       pushes;
        bit       push_ready;
        bit [3:0] ready_pat;
        int       exp_groups;
        int       exp_words;
        int       exp_span;
        int       exp_done;
        bit       exp_busy;
        bit       exp_ovf;
    } job_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_start;
    logic [9:0]          i_num_rows_per_olane;
    result_group_t       i_result;
    logic                i_valid;
    logic [OW-1:0]       o_data;
    logic [2:0]          o_lane;
    logic                o_last;
    logic                o_valid;
    logic                i_ready;
    logic                o_overflow;
    logic                i_clr_overflow;
    logic                o_done;
    logic                o_busy;

    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int words_seen = 0;
    int done_cnt = 0;
    int cyc_cnt = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    int next_g = 0;
    bit stall_prev = 0;
    bit busy_chk = 0;
    logic [OW-1:0] prev_data;
    logic [2:0]    prev_lane;
    logic          prev_last;
    job_t jobs[5];

    always #5 clk = ~clk;

    mvm_result_drain #(
        .OWIDTH(32), .NUM_OLANES(8), .FIFO_DEPTH(16), .MAT_ADDRW(9)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_start              (i_start),
        .i_num_rows_per_olane (i_num_rows_per_olane),
        .i_result             (i_result),
        .i_valid              (i_valid),
        .o_data               (o_data),
        .o_lane               (o_lane),
        .o_last               (o_last),
        .o_valid              (o_valid),
        .i_ready              (i_ready),
        .o_overflow           (o_overflow),
        .i_clr_overflow       (i_clr_overflow),
        .o_done               (o_done),
        .o_busy               (o_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic result_group_t grp(input int g);
        result_group_t r;
        for (int i = 0; i < NL; i++) r[i] = 32'(g * 1000 + (i + 1) * 10);
        return r;
    endfunction

    task automatic enq(input int g);
        result_group_t r;
        r = grp(g);
        for (int i = 0; i < NL; i++) exp_q.push_back({(i == NL - 1), 3'(i), r[i]});
    endtask

    // Monitor/scoreboard: samples 2ns after the falling edge, well away from posedge.
    always @(negedge clk) begin
        logic [EW-1:0] w;
        #2;
        cyc_cnt++;
        if (!rst) begin
            stall_prev = 0;
            busy_chk = 0;
        end else begin
            if (busy_chk) begin
                check("busy_after_done", o_busy, 0);
                busy_chk = 0;
            end
            if (stall_prev) begin
                check("stall_valid", o_valid, 1);
                check("stall_data", o_data, prev_data);
                check("stall_lane", o_lane, prev_lane);
                check("stall_last", o_last, prev_last);
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h with empty expected queue", o_data);
                end else begin
                    w = exp_q.pop_front();
                    check("word", {o_last, o_lane, o_data}, w);
                end
                words_seen++;
                if (first_cyc < 0) first_cyc = cyc_cnt;
                last_cyc = cyc_cnt;
            end
            if (o_done) begin
                done_cnt++;
                busy_chk = 1;
            end
            stall_prev = o_valid && !i_ready;
            prev_data = o_data;
            prev_lane = o_lane;
            prev_last = o_last;
        end
    end

    task automatic run_job(input string tag, input job_t j);
        int cyc;
        int wbase;
        int dbase;
        bit tmo;
        dbase = done_cnt;
        wbase = words_seen;
        first_cyc = -1;
        last_cyc = -1;
        tick();
        i_start = 1;
        i_num_rows_per_olane = 10'(j.rows);
        i_ready = j.push_ready;
        tick();
        i_start = 0;
        for (int g = 0; g < j.pushes; g++) begin
            i_valid = 1;
            i_result = grp(next_g);
            if (g < j.exp_groups) enq(next_g);
            next_g++;
            tick();
        end
        i_valid = 0;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            i_ready = j.ready_pat[3 - (cyc % 4)];
            tick();
            cyc++;
        end
        tmo = (cyc >= 2000);
        if (tmo) exp_q.delete();
        i_ready = 1;
        repeat (4) tick();
        #3;
        check({tag, "_timeout"}, tmo, 0);
        check({tag, "_words"}, 64'(words_seen - wbase), 64'(j.exp_words));
        check({tag, "_done"}, 64'(done_cnt - dbase), 64'(j.exp_done));
        check({tag, "_busy"}, o_busy, j.exp_busy);
        check({tag, "_ovf"}, o_overflow, j.exp_ovf);
        if (j.exp_span >= 0) check({tag, "_span"}, 64'(last_cyc - first_cyc), 64'(j.exp_span));
        tick();
        i_clr_overflow = 1;
        tick();
        i_clr_overflow = 0;
        #3;
        check({tag, "_ovf_clr"}, o_overflow, 0);
    endtask

    initial begin
        int cyc;
        int wbase;
        int dbase;
        job_t jr;

        //            rows pushes prdy pat      grps words span done busy ovf
        jobs[0] = '{  1,   1,    1, 4'b1111,  1,    8,   7,   1,   0,   0};
        jobs[1] = '{  4,   4,    1, 4'b1111,  4,   32,  31,   1,   0,   0};
        jobs[2] = '{  3,   3,    1, 4'b1001,  3,   24,  -1,   1,   0,   0};
        jobs[3] = '{  0,   0,    1, 4'b1111,  0,    0,  -1,   1,   0,   0};
        // Output register holds one group while 16 fill the FIFO; the 18th is dropped.
        jobs[4] = '{ 18,  18,    0, 4'b1111, 17,  136, 135,   0,   1,   1};

        rst = 0;
        i_start = 0;
        i_num_rows_per_olane = '0;
        i_result = '0;
        i_valid = 0;
        i_ready = 0;
        i_clr_overflow = 0;
        repeat (3) tick();
        #3;
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_data", o_data, 0);
        check("rst_lane", o_lane, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_done", o_done, 0);
        check("rst_busy", o_busy, 0);
        tick();
        rst = 1;
        repeat (2) tick();

        // Latency: i_valid in cycle t gives o_valid in t+2 on lane 0.
        dbase = done_cnt;
        i_start = 1;
        i_num_rows_per_olane = 10'd1;
        i_ready = 1;
        tick();
        i_start = 0;
        i_valid = 1;
        i_result = grp(next_g);
        enq(next_g);
        next_g++;
        #3;
        check("lat_t0_valid", o_valid, 0);
        check("lat_busy", o_busy, 1);
        tick();
        i_valid = 0;
        #3;
        check("lat_t1_valid", o_valid, 0);
        tick();
        #3;
        check("lat_t2_valid", o_valid, 1);
        check("lat_t2_lane", o_lane, 0);
        check("lat_t2_data", o_data, 10);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        #3;
        check("lat_timeout", (cyc >= 100), 0);
        check("lat_done", 64'(done_cnt - dbase), 1);

        for (int k = 0; k < 5; k++) run_job($sformatf("job%0d", k), jobs[k]);

        // Full FIFO with a push landing on the lane-7 transfer: push must be kept.
        dbase = done_cnt;
        wbase = words_seen;
        tick();
        i_start = 1;
        i_num_rows_per_olane = 10'd18;
        i_ready = 0;
        tick();
        i_start = 0;
        for (int g = 0; g < 17; g++) begin
            i_valid = 1;
            i_result = grp(next_g);
            enq(next_g);
            next_g++;
            tick();
        end
        i_valid = 0;
        i_ready = 1;
        repeat (6) tick();
        tick();
        i_valid = 1;
        i_result = grp(next_g);
        enq(next_g);
        next_g++;
        #3;
        check("fullpop_lane7", o_lane, 7);
        check("fullpop_valid", o_valid, 1);
        tick();
        i_valid = 0;
        #3;
        check("fullpop_ovf", o_overflow, 0);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 500) begin
            tick();
            cyc++;
        end
        repeat (3) tick();
        #3;
        check("fullpop_timeout", (cyc >= 500), 0);
        check("fullpop_words", 64'(words_seen - wbase), 144);
        check("fullpop_done", 64'(done_cnt - dbase), 1);
        check("fullpop_ovf_end", o_overflow, 0);

        // Reset while group 2 lane 3 is presented.
        dbase = done_cnt;
        wbase = words_seen;
        tick();
        i_start = 1;
        i_num_rows_per_olane = 10'd4;
        i_ready = 1;
        tick();
        i_start = 0;
        for (int g = 0; g < 4; g++) begin
            i_valid = 1;
            i_result = grp(next_g);
            enq(next_g);
            next_g++;
            tick();
        end
        i_valid = 0;
        cyc = 0;
        while ((words_seen - wbase) < 19 && cyc < 500) begin
            tick();
            cyc++;
        end
        check("rstmid_timeout", (cyc >= 500), 0);
        #1;
        check("rstmid_lane_at_rst", o_lane, 3);
        rst = 0;
        exp_q.delete();
        tick();
        rst = 1;
        #3;
        check("rstmid_valid", o_valid, 0);
        check("rstmid_last", o_last, 0);
        check("rstmid_data", o_data, 0);
        check("rstmid_lane", o_lane, 0);
        check("rstmid_ovf", o_overflow, 0);
        check("rstmid_done", o_done, 0);
        check("rstmid_busy", o_busy, 0);
        repeat (4) tick();
        #3;
        check("rstmid_flushed", o_valid, 0);
        check("rstmid_no_done", 64'(done_cnt - dbase), 0);
        jr = '{1, 1, 1, 4'b1111, 1, 8, 7, 1, 0, 0};
        run_job("after_rst", jr);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
